// File: rtl/coincidence_stimulus_gen.sv
// coincidence_stimulus_gen
// Burst generator for leader/follower pulse pairs that drive the button_A/button_B
// inputs of the coincidence path. On start it emits `count` frames. In each frame
// the follower pulse trails the leader pulse by `delay` cycles. All outputs are registered.
module coincidence_stimulus_gen #(
    parameter int CNT_W = 8,
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             lead_sel,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] width,
    input  logic [PER_W-1:0] period,
    input  logic [CNT_W-1:0] count,
    output logic             pulse_A,
    output logic             pulse_B,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulses_sent
);

    // Frame arithmetic is one bit wider than period, so delay+width+1 cannot overflow.
    localparam int FW = PER_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q;
    logic             lsel_q;
    logic [CNT_W-1:0] delay_q;
    logic [CNT_W-1:0] ew_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] sent_q;
    logic [FW-1:0]    flen_q;
    logic [FW-1:0]    fc_q;
    logic             pulse_a_q;
    logic             pulse_b_q;
    logic             busy_q;
    logic             done_q;

    logic [CNT_W-1:0] ew_d;
    logic [FW-1:0]    min_len_d;
    logic [FW-1:0]    flen_d;
    logic [FW-1:0]    fc_d;
    logic [CNT_W-1:0] sent_d;
    logic [1:0]       pair_start_d;
    logic [1:0]       pair_first_d;
    logic [1:0]       pair_next_d;
    logic             frame_end_d;

    // Returns {A, B} for frame offset fc. lsel=0 means A leads.
    function automatic logic [1:0] pulse_pair(input logic [FW-1:0]    fc,
                                              input logic [CNT_W-1:0] dly,
                                              input logic [CNT_W-1:0] ew,
                                              input logic             lsel);
        logic lead;
        logic fol;
        lead = (fc < FW'(ew));
        fol  = (fc >= FW'(dly)) && (fc < (FW'(dly) + FW'(ew)));
        return lsel ? {fol, lead} : {lead, fol};
    endfunction

    // Clamp the incoming configuration and precompute the next frame step.
    always_comb begin
        ew_d         = (width == '0) ? CNT_W'(1) : width;
        min_len_d    = FW'(delay) + FW'(ew_d) + FW'(1);
        flen_d       = (FW'(period) > min_len_d) ? FW'(period) : min_len_d;
        fc_d         = fc_q + FW'(1);
        sent_d       = sent_q + CNT_W'(1);
        frame_end_d  = (fc_q == (flen_q - FW'(1)));
        pair_start_d = pulse_pair('0, delay, ew_d, lead_sel);
        pair_first_d = pulse_pair('0, delay_q, ew_q, lsel_q);
        pair_next_d  = pulse_pair(fc_d, delay_q, ew_q, lsel_q);
    end

    // Control FSM. Each output register is loaded with the value for the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            fc_q      <= '0;
            sent_q    <= '0;
            pulse_a_q <= 1'b0;
            pulse_b_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    pulse_a_q <= 1'b0;
                    pulse_b_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    if (start) begin
                        lsel_q  <= lead_sel;
                        delay_q <= delay;
                        ew_q    <= ew_d;
                        flen_q  <= flen_d;
                        count_q <= count;
                        sent_q  <= '0;
                        fc_q    <= '0;
                        if (count == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q                <= S_RUN;
                            busy_q                 <= 1'b1;
                            {pulse_a_q, pulse_b_q} <= pair_start_d;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state_q   <= S_IDLE;
                        pulse_a_q <= 1'b0;
                        pulse_b_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else if (frame_end_d) begin
                        sent_q <= sent_d;
                        if (sent_d == count_q) begin
                            state_q   <= S_DONE;
                            pulse_a_q <= 1'b0;
                            pulse_b_q <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            fc_q                   <= '0;
                            {pulse_a_q, pulse_b_q} <= pair_first_d;
                        end
                    end else begin
                        fc_q                   <= fc_d;
                        {pulse_a_q, pulse_b_q} <= pair_next_d;
                    end
                end
                default: begin
                    // DONE lasts one cycle. An abort here leads to the same IDLE state.
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pulse_A     = pulse_a_q;
    assign pulse_B     = pulse_b_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pulses_sent = sent_q;

endmodule

// File: tb/tb_coincidence_stimulus_gen.sv
// Testbench for coincidence_stimulus_gen. Expected outputs come from the closed-form
// timing of a burst and are queued per cycle. They are compared one cycle later.
module tb_coincidence_stimulus_gen;

    localparam int CNT_W = 8;
    localparam int PER_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic             lead_sel;
    logic [CNT_W-1:0] delay;
    logic [CNT_W-1:0] width;
    logic [PER_W-1:0] period;
    logic [CNT_W-1:0] count;
    logic             pulse_A;
    logic             pulse_B;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pulses_sent;

    typedef struct {
        int lsel;
        int dly;
        int wid;
        int per;
        int cnt;
    } cfg_t;

    logic [CNT_W+3:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    coincidence_stimulus_gen #(.CNT_W(CNT_W), .PER_W(PER_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .lead_sel(lead_sel),
        .delay(delay), .width(width), .period(period), .count(count),
        .pulse_A(pulse_A), .pulse_B(pulse_B), .busy(busy), .done(done),
        .pulses_sent(pulses_sent)
    );

    always #5 clk = ~clk;

    function automatic int sent_at(int t, int flen, int cnt);
        int s;
        if (t < 1) return 0;
        s = (t - 1) / flen;
        return (s > cnt) ? cnt : s;
    endfunction

    // Expected {A, B, busy, done, pulses_sent} in cycle t, for a start at cycle 0.
    function automatic logic [CNT_W+3:0] model(int t, cfg_t c, int abort_at, int rst_at);
        int ew, flen, off;
        logic lead, fol, a, b, bsy, dn;
        ew   = (c.wid == 0) ? 1 : c.wid;
        flen = (c.per > c.dly + ew + 1) ? c.per : c.dly + ew + 1;
        if (rst_at >= 0 && t > rst_at) return '0;
        if (abort_at >= 0 && t > abort_at)
            return {4'b0000, CNT_W'(sent_at(abort_at, flen, c.cnt))};
        bsy = (t >= 1) && (t <= c.cnt * flen);
        dn  = (t == c.cnt * flen + 1);
        a = 1'b0;
        b = 1'b0;
        if (bsy) begin
            off  = (t - 1) % flen;
            lead = (off < ew);
            fol  = (off >= c.dly) && (off < c.dly + ew);
            a = (c.lsel != 0) ? fol : lead;
            b = (c.lsel != 0) ? lead : fol;
        end
        return {a, b, bsy, dn, CNT_W'(sent_at(t, flen, c.cnt))};
    endfunction

    task automatic check_cycle(input string tag, input int cyc);
        logic [CNT_W+3:0] obs, expv;
        obs  = {pulse_A, pulse_B, busy, done, pulses_sent};
        expv = exp_q.pop_front();
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s cycle %0d: observed A,B,busy,done,sent=%h expected %h", tag, cyc, obs, expv);
        end
    endtask

    // Drives one burst from cycle 0 and checks cycles 1..n. Config inputs are scrambled after cycle 0.
    task automatic run_burst(input cfg_t c, input int n, input int extra_start,
                             input int abort_at, input int rst_at, input string tag);
        for (int t = 0; t < n; t++) begin
            if (t == 0) begin
                lead_sel = c.lsel[0];
                delay    = CNT_W'(c.dly);
                width    = CNT_W'(c.wid);
                period   = PER_W'(c.per);
                count    = CNT_W'(c.cnt);
            end else begin
                lead_sel = 1'($urandom);
                delay    = CNT_W'($urandom);
                width    = CNT_W'($urandom);
                period   = PER_W'($urandom);
                count    = CNT_W'($urandom);
            end
            start = (t == 0) || (t == extra_start);
            abort = (t == abort_at);
            rst   = (t == rst_at);
            exp_q.push_back(model(t + 1, c, abort_at, rst_at));
            @(posedge clk);
            #1;
            check_cycle(tag, t + 1);
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
    endtask

    cfg_t base_c, clamp_c, simul_c, empty_c;

    initial begin
        base_c  = '{lsel: 0, dly: 3, wid: 2, per: 10, cnt: 2};
        clamp_c = '{lsel: 0, dly: 5, wid: 0, per: 3,  cnt: 1};
        simul_c = '{lsel: 1, dly: 0, wid: 4, per: 8,  cnt: 3};
        empty_c = '{lsel: 0, dly: 2, wid: 3, per: 9,  cnt: 0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; lead_sel = 1'b0;
        delay = '0; width = '0; period = '0; count = '0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('0);
            @(posedge clk);
            #1;
            check_cycle("reset", i);
        end
        rst = 1'b0;
        abort = 1'b1;
        exp_q.push_back('0);
        @(posedge clk);
        #1;
        check_cycle("idle_abort", 0);
        abort = 1'b0;

        // A start sampled in the DONE cycle (21) is ignored.
        run_burst(base_c, 24, 21, -1, -1, "basic");
        run_burst(clamp_c, 10, -1, -1, -1, "clamp");
        run_burst(simul_c, 28, -1, -1, -1, "simul");
        run_burst(empty_c, 4, -1, -1, -1, "empty");
        // A start in cycle 5 is ignored. The abort in cycle 12 keeps pulses_sent=1.
        run_burst(base_c, 25, 5, 12, -1, "abort");
        // Reset in cycle 4, then a fresh start at global cycle 6.
        run_burst(base_c, 6, -1, -1, 4, "rst_mid");
        run_burst(base_c, 24, -1, -1, -1, "after_rst");

        tests++;
        assert (exp_q.size() == 0) else begin
            fails++;
            $error("FAIL queue_drain: observed %0d left expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
